// File: rtl/round_sequencer.sv
// Game-round sequencer: latches the speed period at game start, then runs ROUNDS
// rounds of SHOW (display/response window) followed by GAP, counting user hits.
module round_sequencer #(
  parameter int PERIOD_NORMAL = 1000,
  parameter int PERIOD_INTER  = 750,
  parameter int PERIOD_ADV    = 500,
  parameter int GAP_CYCLES    = 200,
  parameter int ROUNDS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_speed,
  input  logic       config_valid,
  input  logic       start,
  input  logic       user_hit,
  output logic       new_num,
  output logic       show,
  output logic [3:0] round,
  output logic [3:0] hits,
  output logic       busy,
  output logic       done
);

  localparam int M1   = (PERIOD_NORMAL > PERIOD_INTER) ? PERIOD_NORMAL : PERIOD_INTER;
  localparam int M2   = (PERIOD_ADV > GAP_CYCLES) ? PERIOD_ADV : GAP_CYCLES;
  localparam int MAXV = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] period, period_n;
  logic [CW-1:0] psel;
  logic [3:0]    round_n, hits_n;
  logic          new_num_n, show_n, busy_n, done_n;
  logic          go;

  // Reserved code 2'b11 runs at the advanced rate.
  always_comb begin
    case (game_speed)
      2'b00:   psel = CW'(PERIOD_NORMAL);
      2'b01:   psel = CW'(PERIOD_INTER);
      default: psel = CW'(PERIOD_ADV);
    endcase
  end

  assign go = start && config_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      round   <= '0;
      hits    <= '0;
      new_num <= 1'b0;
      show    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      period  <= period_n;
      round   <= round_n;
      hits    <= hits_n;
      new_num <= new_num_n;
      show    <= show_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period;
    round_n  = round;
    hits_n   = hits;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_n  = SHOW;
          period_n = psel;
          cnt_n    = psel - CW'(1);
          round_n  = '0;
          hits_n   = '0;
        end
      end
      SHOW: begin
        // A hit ends the window at once, so only one hit per round can land.
        if (user_hit || cnt == '0) begin
          state_n = GAP;
          cnt_n   = CW'(GAP_CYCLES - 1);
          if (user_hit && hits != 4'hf) hits_n = hits + 4'd1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (round == 4'(ROUNDS - 1)) begin
            state_n = DONE;
          end else begin
            state_n = SHOW;
            round_n = round + 4'd1;
            cnt_n   = period - CW'(1);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    new_num_n = (state_n == SHOW) && (state != SHOW);
    show_n    = (state_n == SHOW);
    busy_n    = (state_n == SHOW) || (state_n == GAP);
    done_n    = (state_n == DONE);
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with shortened periods (8/6/4, gap 3, 3 rounds).
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_speed;
  logic       config_valid;
  logic       start;
  logic       user_hit;
  logic       new_num, show, busy, done;
  logic [3:0] round, hits;

  int tests = 0;
  int fails = 0;

  round_sequencer #(
    .PERIOD_NORMAL(8), .PERIOD_INTER(6), .PERIOD_ADV(4), .GAP_CYCLES(3), .ROUNDS(3)
  ) dut (
    .clk(clk), .rst(rst), .game_speed(game_speed), .config_valid(config_valid),
    .start(start), .user_hit(user_hit), .new_num(new_num), .show(show),
    .round(round), .hits(hits), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [1:0] spd);
    game_speed = spd; config_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observes a game from its first SHOW cycle (index 0) until done rises.
  task automatic measure(output int w0, output int w1, output int w2,
                         output int nn, output int nngap, output int total);
    int last;
    last = -1; w0 = 0; w1 = 0; w2 = 0; nn = 0; nngap = 0; total = -1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin total = c; break; end
      if (show) begin
        if (round == 4'd0) w0++; else if (round == 4'd1) w1++; else w2++;
      end
      if (new_num) begin
        if (last >= 0) begin
          if (nngap == 0) nngap = c - last;
          else if (nngap != c - last) nngap = -1;
        end
        last = c; nn++;
      end
      tick();
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < 400) begin tick(); c++; end
    tests++;
    if (!done) begin fails++; $display("FAIL %s_timeout done=%0b required 1", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; game_speed = 2'b00; config_valid = 1'b0; start = 1'b0; user_hit = 1'b0;
    tick(); tick();
    tests++;
    if ({new_num, show, busy, done, round, hits} !== 12'h0) begin
      fails++; $display("FAIL reset_outputs got %h required 000", {new_num, show, busy, done, round, hits});
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({new_num, show, busy, done, round, hits} !== 12'h0) begin
      fails++; $display("FAIL idle_outputs got %h required 000", {new_num, show, busy, done, round, hits});
    end
  endtask

  task automatic test_gating();
    int sw;
    game_speed = 2'b00; config_valid = 1'b0; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    tests++;
    if ({new_num, show, busy, done, round, hits} !== 12'h0) begin
      fails++; $display("FAIL gate_no_cfg got %h required 000", {new_num, show, busy, done, round, hits});
    end
    start_game(2'b00);
    tests++;
    if (new_num !== 1'b1 || show !== 1'b1 || round !== 4'd0) begin
      fails++; $display("FAIL start_latency new_num=%0b show=%0b round=%0d required 1 1 0", new_num, show, round);
    end
    // idx0..10 spans round 0; a start pulse at idx2 must not disturb it
    sw = 0;
    for (int c = 0; c < 11; c++) begin
      if (show) sw++;
      start = (c == 2);
      tick();
    end
    start = 1'b0;
    tests++;
    if (sw != 8) begin fails++; $display("FAIL start_in_show width=%0d required 8", sw); end
    tests++;
    if (new_num !== 1'b1 || round !== 4'd1) begin
      fails++; $display("FAIL start_in_show_round new_num=%0b round=%0d required 1 1", new_num, round);
    end
  endtask

  task automatic test_async_reset();
    int nnc;
    // now at idx11 (round 1, first SHOW cycle); gap of round 1 starts at idx19
    repeat (8) tick();
    tests++;
    if (show !== 1'b0 || busy !== 1'b1 || round !== 4'd1) begin
      fails++; $display("FAIL pre_reset_gap show=%0b busy=%0b round=%0d required 0 1 1", show, busy, round);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({new_num, show, busy, done, round, hits} !== 12'h0) begin
      fails++; $display("FAIL async_reset got %h required 000", {new_num, show, busy, done, round, hits});
    end
    tick();
    rst = 1'b0;
    nnc = 0;
    for (int c = 0; c < 6; c++) begin
      if (new_num || busy) nnc++;
      tick();
    end
    tests++;
    if (nnc != 0) begin fails++; $display("FAIL post_reset_idle active_cycles=%0d required 0", nnc); end
    start_game(2'b00);
    tests++;
    if (new_num !== 1'b1 || show !== 1'b1 || round !== 4'd0 || hits !== 4'd0) begin
      fails++; $display("FAIL restart_after_reset new_num=%0b show=%0b round=%0d hits=%0d required 1 1 0 0",
                        new_num, show, round, hits);
    end
    wait_done("after_reset");
  endtask

  task automatic test_full_game();
    int w0, w1, w2, nn, g, t;
    start_game(2'b00);
    measure(w0, w1, w2, nn, g, t);
    tests++;
    if (w0 != 8 || w1 != 8 || w2 != 8) begin
      fails++; $display("FAIL normal_widths got %0d %0d %0d required 8 8 8", w0, w1, w2);
    end
    tests++;
    if (nn != 3 || g != 11) begin fails++; $display("FAIL new_num_pulses count=%0d spacing=%0d required 3 11", nn, g); end
    tests++;
    if (t != 33) begin fails++; $display("FAIL done_time got %0d required 33", t); end
    tests++;
    if (round !== 4'd2 || hits !== 4'd0 || busy !== 1'b0 || show !== 1'b0) begin
      fails++; $display("FAIL final_state round=%0d hits=%0d busy=%0b show=%0b required 2 0 0 0", round, hits, busy, show);
    end
  endtask

  task automatic test_speed_map();
    logic [1:0] spd [3];
    int         wexp [3];
    int w0, w1, w2, nn, g, t;
    spd[0] = 2'b01; spd[1] = 2'b10; spd[2] = 2'b11;
    wexp[0] = 6;    wexp[1] = 4;    wexp[2] = 4;
    for (int i = 0; i < 3; i++) begin
      start_game(spd[i]);
      game_speed = 2'b00;   // ignored until the next game
      config_valid = 1'b0;
      measure(w0, w1, w2, nn, g, t);
      tests++;
      if (w0 != wexp[i] || w1 != wexp[i] || w2 != wexp[i] || t != 3 * (wexp[i] + 3)) begin
        fails++; $display("FAIL speed_%0d widths=%0d %0d %0d total=%0d required %0d each total %0d",
                          i, w0, w1, w2, t, wexp[i], 3 * (wexp[i] + 3));
      end
    end
  endtask

  task automatic test_hits();
    start_game(2'b00);                        // idx0
    tick();                                   // idx1
    user_hit = 1'b1; tick(); user_hit = 1'b0; // idx2
    tests++;
    if (show !== 1'b0 || busy !== 1'b1 || hits !== 4'd1) begin
      fails++; $display("FAIL hit_early show=%0b busy=%0b hits=%0d required 0 1 1", show, busy, hits);
    end
    user_hit = 1'b1; tick(); user_hit = 1'b0; // idx3, hit in GAP
    tests++;
    if (hits !== 4'd1 || show !== 1'b0) begin
      fails++; $display("FAIL hit_in_gap hits=%0d show=%0b required 1 0", hits, show);
    end
    tick(); tick();                           // idx5
    tests++;
    if (new_num !== 1'b1 || show !== 1'b1 || round !== 4'd1) begin
      fails++; $display("FAIL gap_len new_num=%0b show=%0b round=%0d required 1 1 1", new_num, show, round);
    end
    repeat (7) tick();                        // idx12, last SHOW cycle
    tests++;
    if (show !== 1'b1) begin fails++; $display("FAIL last_show_cycle show=%0b required 1", show); end
    user_hit = 1'b1; tick(); user_hit = 1'b0; // idx13
    tests++;
    if (hits !== 4'd2 || show !== 1'b0) begin
      fails++; $display("FAIL hit_last_cycle hits=%0d show=%0b required 2 0", hits, show);
    end
    wait_done("hits");
    user_hit = 1'b1; tick(); user_hit = 1'b0;
    tests++;
    if (hits !== 4'd2 || round !== 4'd2) begin
      fails++; $display("FAIL hits_final hits=%0d round=%0d required 2 2", hits, round);
    end
  endtask

  task automatic test_restart();
    int w0, w1, w2, nn, g, t;
    config_valid = 1'b0; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || hits !== 4'd2) begin
      fails++; $display("FAIL done_no_cfg done=%0b busy=%0b hits=%0d required 1 0 2", done, busy, hits);
    end
    start_game(2'b10);
    tests++;
    if (new_num !== 1'b1 || done !== 1'b0 || round !== 4'd0 || hits !== 4'd0) begin
      fails++; $display("FAIL restart new_num=%0b done=%0b round=%0d hits=%0d required 1 0 0 0",
                        new_num, done, round, hits);
    end
    measure(w0, w1, w2, nn, g, t);
    tests++;
    if (w0 != 4 || w1 != 4 || w2 != 4 || nn != 3 || t != 21) begin
      fails++; $display("FAIL restart_period widths=%0d %0d %0d nn=%0d total=%0d required 4 4 4 3 21",
                        w0, w1, w2, nn, t);
    end
  endtask

  initial begin
    test_reset();
    test_gating();
    test_async_reset();
    test_full_game();
    test_speed_map();
    test_hits();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
